uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Receive-side framer for the two-byte command protocol the trading front end sends over UART.
//  Sits after uart_rx: consumes the byte stream (rx_byte/rx_done) and rebuilds {cmd, arg} frames.
//  Validates each frame, then presents it downstream on a valid/ready interface.
//  Keeps saturating frame and error statistics for the seven-segment display and debug.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max clk cycles between cmd and arg byte (10 ms @ 100 MHz)
//  CNT_W           16         width of frame_cnt
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   reset, synchronous, active-low
//  rx_byte     in   8   byte from uart_rx, valid only while rx_done=1
//  rx_done     in   1   one-cycle strobe, new byte on rx_byte
//  out_ready   in   1   downstream accepts the frame when out_valid=1 and out_ready=1
//  out_valid   out  1   frame held on out_cmd/out_arg
//  out_cmd     out  8   command: 01 key, 02 buy, 03 sell, 04 close, 05 report, 06 heartbeat
//  out_arg     out  8   ASCII key code (cmd 01) or pair id 01/02 (cmd 02..06)
//  err_pulse   out  1   one-cycle strobe on any dropped frame or byte
//  err_code    out  2   valid with err_pulse: 1 bad cmd, 2 bad arg, 3 timeout / overflow
//  frame_cnt   out  CNT_W  accepted frames, saturating
//  err_cnt     out  8   total errors, saturating at 8'hFF
// BEHAVIOUR
//  Reset: state=IDLE, timer=0, out_valid=0, out_cmd=out_arg=0, err_pulse=0, err_code=0, both counters=0.
//  Reset takes priority over everything, including mid-frame. A partial frame is discarded silently.
//  FSM IDLE:
//   - rx_done with rx_byte in 01..06: latch cmd, clear timer, go to WAIT_ARG.
//   - rx_done with any other byte: err_pulse, code 1, stay in IDLE (resync on the next byte).
//  FSM WAIT_ARG, per cycle:
//   - rx_done has priority over timer expiry in the same cycle.
//   - rx_done: latch arg, go to CHECK.
//   - else timer==TIMEOUT_CYCLES-1: err_pulse, code 3, go to IDLE.
//   - else timer+1.
//  FSM CHECK (one cycle; rx_done ignored here, uart_rx byte spacing makes this safe):
//   - cmd 02..06 with arg not in {01,02}: err code 2, go to IDLE.
//   - cmd 01 accepts any arg.
//   - Valid frame, output slot free (out_valid=0, or out_valid&out_ready this cycle):
//     load out_cmd/out_arg, out_valid=1 next cycle, frame_cnt+1.
//   - Valid frame, slot occupied and not being drained: frame dropped, err code 3, output unchanged.
//   - Always return to IDLE.
//  Latency: out_valid rises 2 clk after the rx_done of the arg byte.
//  Output handshake:
//   - out_cmd/out_arg stay stable while out_valid=1 and out_ready=0.
//   - out_valid falls the cycle after out_valid&out_ready unless a new frame is loaded in the same cycle.
//  err_pulse is registered and high for exactly 1 cycle per error; err_cnt increments in that same cycle.
//  At most one error per cycle by construction.
//  Counters saturate: frame_cnt at all-ones, err_cnt at FF; neither wraps.
// TESTING
//  1. Send bytes 02,01 with out_ready=1 -> out_valid 1 cycle, cmd=02 arg=01, 2 clk after 2nd rx_done; frame_cnt=1.
//  2. Send 01,'A'(41) with out_ready=0 for 100 cycles, then send 03,02 -> first frame held stable;
//     2nd frame dropped, err_code=3, err_cnt=1; raise out_ready -> cmd=01 arg=41 consumed.
//  3. Send 07 then 04,02 -> err_code=1 on 07, then frame cmd=04 arg=02 accepted (resync).
//  4. Send 05,03 -> err_code=2, no out_valid; frame_cnt unchanged.
//  5. Send 06, wait TIMEOUT_CYCLES with no byte -> err_code=3 on the expiry cycle, state IDLE.
//     Repeat with the arg byte arriving on exactly the expiry cycle -> frame accepted, no error.
//  6. Send 02, drop rst_n for 1 cycle, then send 01 -> no frame, no error; then 02,01 -> accepted normally.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Receive-side framer for the two-byte {cmd, arg} UART command protocol.
// Rebuilds frames from the uart_rx byte stream, validates them and presents them on valid/ready.
module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_byte,
  input  logic             rx_done,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_cmd,
  output logic [7:0]       out_arg,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       err_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_CMD = 2'd1;
  localparam logic [1:0] ERR_ARG = 2'd2;
  localparam logic [1:0] ERR_OVF = 2'd3;

  localparam logic [7:0] CMD_KEY = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ARG,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       arg_q, arg_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_cmd_q, out_cmd_d;
  logic [7:0]       out_arg_q, out_arg_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             drain;
  logic             load;
  logic             err;
  logic [1:0]       code;

  function automatic logic cmd_ok(input logic [7:0] b);
    return (b >= 8'h01) && (b <= 8'h06);
  endfunction

  function automatic logic pair_ok(input logic [7:0] b);
    return (b == 8'h01) || (b == 8'h02);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_frame(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    out_valid_d = out_valid_q;
    out_cmd_d   = out_cmd_q;
    out_arg_d   = out_arg_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    drain       = out_valid_q & out_ready;
    load        = 1'b0;
    err         = 1'b0;
    code        = 2'd0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_done) begin
          if (cmd_ok(rx_byte)) begin
            cmd_d   = rx_byte;
            timer_d = '0;
            state_d = S_WAIT_ARG;
          end else begin
            // Stay in IDLE so the very next byte is tried as a command (resync).
            err  = 1'b1;
            code = ERR_CMD;
          end
        end
      end
      S_WAIT_ARG: begin
        if (rx_done) begin
          arg_d   = rx_byte;
          state_d = S_CHECK;
        end else if (timer_q == TIMER_LAST) begin
          err     = 1'b1;
          code    = ERR_OVF;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if ((cmd_q != CMD_KEY) && !pair_ok(arg_q)) begin
          err  = 1'b1;
          code = ERR_ARG;
        end else if (!out_valid_q || drain) begin
          load = 1'b1;
        end else begin
          err  = 1'b1;
          code = ERR_OVF;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A load in the same cycle as a drain keeps out_valid high with the new frame.
    if (load) begin
      out_valid_d = 1'b1;
      out_cmd_d   = cmd_q;
      out_arg_d   = arg_q;
      frame_cnt_d = sat_inc_frame(frame_cnt_q);
    end else if (drain) begin
      out_valid_d = 1'b0;
    end

    if (err) begin
      err_pulse_d = 1'b1;
      err_code_d  = code;
      err_cnt_d   = sat_inc_err(err_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= 8'h00;
      out_arg_q   <= 8'h00;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
      frame_cnt_q <= '0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
      out_arg_q   <= out_arg_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Frame bytes under assembly carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
    arg_q <= arg_d;
  end

  assign out_valid = out_valid_q;
  assign out_cmd   = out_cmd_q;
  assign out_arg   = out_arg_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: event-level protocol model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_uart_cmd_parser;

  localparam int T  = 40;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_done = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [7:0]    out_cmd;
  logic [7:0]    out_arg;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic [CW-1:0] frame_cnt;
  logic [7:0]    err_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_parser #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_done(rx_done),
    .out_ready(out_ready), .out_valid(out_valid), .out_cmd(out_cmd),
    .out_arg(out_arg), .err_pulse(err_pulse), .err_code(err_code),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol model: a pending command byte with its arrival cycle, a frame awaiting
  // its one-cycle validation, and the downstream output slot.
  longint     cyc = 0;
  longint     m_cmd_cyc = 0;
  bit         m_have_cmd = 0;
  bit         m_chk = 0;
  logic [7:0] m_pcmd = 0, m_fcmd = 0, m_farg = 0;
  bit         m_valid = 0;
  logic [7:0] m_cmd = 0, m_arg = 0;
  bit         m_err = 0;
  int         m_code = 0, m_fcnt = 0, m_ecnt = 0;

  always @(posedge clk) begin
    bit drained, loaded, e;
    int c;
    cyc++;
    if (!rst_n) begin
      m_have_cmd = 0; m_chk = 0; m_valid = 0; m_cmd = 0; m_arg = 0;
      m_err = 0; m_code = 0; m_fcnt = 0; m_ecnt = 0;
    end else begin
      drained = m_valid && out_ready;
      loaded = 0; e = 0; c = 0;
      if (m_chk) begin
        m_chk = 0;
        if (m_fcmd != 8'h01 && m_farg != 8'h01 && m_farg != 8'h02) begin
          e = 1; c = 2;
        end else if (!m_valid || drained) begin
          loaded = 1; m_cmd = m_fcmd; m_arg = m_farg;
          if (m_fcnt != (1 << CW) - 1) m_fcnt++;
        end else begin
          e = 1; c = 3;
        end
      end else if (m_have_cmd) begin
        if (rx_done) begin
          m_chk = 1; m_fcmd = m_pcmd; m_farg = rx_byte; m_have_cmd = 0;
        end else if (cyc - m_cmd_cyc == T) begin
          e = 1; c = 3; m_have_cmd = 0;
        end
      end else if (rx_done) begin
        if (rx_byte >= 8'd1 && rx_byte <= 8'd6) begin
          m_have_cmd = 1; m_pcmd = rx_byte; m_cmd_cyc = cyc;
        end else begin
          e = 1; c = 1;
        end
      end
      if (loaded) m_valid = 1;
      else if (drained) m_valid = 0;
      m_err = e;
      if (e) begin
        m_code = c;
        if (m_ecnt != 255) m_ecnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", int'(out_valid), int'(m_valid));
      check("out_cmd", int'(out_cmd), int'(m_cmd));
      check("out_arg", int'(out_arg), int'(m_arg));
      check("err_pulse", int'(err_pulse), int'(m_err));
      if (m_err) check("err_code", int'(err_code), m_code);
      check("frame_cnt", int'(frame_cnt), m_fcnt);
      check("err_cnt", int'(err_cnt), m_ecnt);
    end
  end

  // Called at a negedge; the byte is sampled on the next posedge and the task
  // returns at the negedge right after it.
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    check("rst_valid", int'(out_valid), 0);
    check("rst_cmd", int'(out_cmd), 0);
    check("rst_arg", int'(out_arg), 0);
    check("rst_err", int'(err_pulse), 0);
    check("rst_code", int'(err_code), 0);
    check("rst_fcnt", int'(frame_cnt), 0);
    check("rst_ecnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Basic frame, latency 2 clk after the arg byte
    out_ready = 1'b1;
    send(8'h02); idle(2); send(8'h01);
    check("t1_valid_early", int'(out_valid), 0);
    idle(1);
    check("t1_valid", int'(out_valid), 1);
    check("t1_cmd", int'(out_cmd), 8'h02);
    check("t1_arg", int'(out_arg), 8'h01);
    check("t1_fcnt", int'(frame_cnt), 1);
    idle(1);
    check("t1_valid_fall", int'(out_valid), 0);

    // Backpressure: held frame, second frame dropped as overflow
    out_ready = 1'b0;
    send(8'h01); idle(2); send(8'h41); idle(100);
    check("t2_hold_valid", int'(out_valid), 1);
    check("t2_hold_cmd", int'(out_cmd), 8'h01);
    check("t2_hold_arg", int'(out_arg), 8'h41);
    send(8'h03); idle(2); send(8'h02); idle(1);
    check("t2_err", int'(err_pulse), 1);
    check("t2_code", int'(err_code), 3);
    check("t2_ecnt", int'(err_cnt), 1);
    check("t2_still_arg", int'(out_arg), 8'h41);
    out_ready = 1'b1;
    idle(1);
    check("t2_consumed", int'(out_valid), 0);
    check("t2_fcnt", int'(frame_cnt), 2);

    // Bad command then resync
    idle(2);
    send(8'h07);
    check("t3_err", int'(err_pulse), 1);
    check("t3_code", int'(err_code), 1);
    check("t3_ecnt", int'(err_cnt), 2);
    idle(2); send(8'h04); idle(2); send(8'h02); idle(1);
    check("t3_valid", int'(out_valid), 1);
    check("t3_cmd", int'(out_cmd), 8'h04);
    check("t3_arg", int'(out_arg), 8'h02);

    // Bad pair id
    idle(2); send(8'h05); idle(2); send(8'h03); idle(1);
    check("t4_err", int'(err_pulse), 1);
    check("t4_code", int'(err_code), 2);
    check("t4_valid", int'(out_valid), 0);
    check("t4_fcnt", int'(frame_cnt), 3);

    // Timeout, then arg arriving exactly on the expiry cycle
    idle(2); send(8'h06); idle(T - 1);
    check("t5_no_err_yet", int'(err_pulse), 0);
    idle(1);
    check("t5_err", int'(err_pulse), 1);
    check("t5_code", int'(err_code), 3);
    check("t5_ecnt", int'(err_cnt), 4);
    idle(2); send(8'h06); idle(T - 1); send(8'h01);
    check("t5b_no_err", int'(err_pulse), 0);
    idle(1);
    check("t5b_valid", int'(out_valid), 1);
    check("t5b_cmd", int'(out_cmd), 8'h06);
    check("t5b_ecnt", int'(err_cnt), 4);

    // Reset mid-frame discards the partial frame
    idle(2); send(8'h02);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    check("t6_fcnt_rst", int'(frame_cnt), 0);
    send(8'h01); idle(3);
    check("t6_no_valid", int'(out_valid), 0);
    check("t6_no_err", int'(err_cnt), 0);
    send(8'h41); idle(1);
    check("t6_key_frame", int'(out_arg), 8'h41);
    idle(2); send(8'h02); idle(2); send(8'h01); idle(1);
    check("t6_valid", int'(out_valid), 1);
    check("t6_cmd", int'(out_cmd), 8'h02);
    check("t6_fcnt", int'(frame_cnt), 2);

    // Byte during validation cycle is ignored
    idle(2); send(8'h02); send(8'h01); send(8'h07);
    check("t7_ignored", int'(err_cnt), 0);
    check("t7_valid", int'(out_valid), 1);
    idle(3);

    // Drain and load in the same cycle
    out_ready = 1'b0;
    send(8'h02); idle(2); send(8'h02); idle(2);
    send(8'h03); idle(2); send(8'h01);
    out_ready = 1'b1;
    idle(1);
    check("t8_valid", int'(out_valid), 1);
    check("t8_cmd", int'(out_cmd), 8'h03);
    check("t8_err", int'(err_pulse), 0);
    idle(1);
    check("t8_fall", int'(out_valid), 0);
    check("t8_fcnt", int'(frame_cnt), 5);

    // Saturation of both counters
    for (int i = 0; i < 16; i++) begin
      send(8'h01); idle(1); send(8'h30 + 8'(i)); idle(2);
    end
    check("sat_fcnt", int'(frame_cnt), 15);
    for (int i = 0; i < 260; i++) begin
      send(8'hFF); idle(1);
    end
    check("sat_ecnt", int'(err_cnt), 255);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
